nibble_input_latch: RTL



---
 rtl/nibble_input_latch_pkg.sv | 8 +
 rtl/nibble_input_latch_if.sv | 19 +
 rtl/nibble_input_latch_debounce_filter.sv | 39 +++
 rtl/nibble_input_latch.sv | 60 ++++++
 4 files changed

// File: rtl/nibble_input_latch_pkg.sv
// nibble_input_latch_pkg: shared FSM state encoding and default debounce length
package nibble_input_latch_pkg;
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_REL = 1'b1
  } state_e;
  localparam int DEBOUNCE_1MS_50MHZ = 50000;
endpackage

// File: rtl/nibble_input_latch_if.sv
// nibble_input_latch_if: raw switch/button inputs and latched code outputs of the nibble latch
interface nibble_input_latch_if;
  logic [3:0] sw_raw;
  logic       btn_load_raw;
  logic       A0;
  logic       A1;
  logic       A2;
  logic       A3;
  logic       code_valid;
  logic [3:0] sw_stable;
  modport master (
    output sw_raw, btn_load_raw,
    input  A0, A1, A2, A3, code_valid, sw_stable
  );
  modport slave (
    input  sw_raw, btn_load_raw,
    output A0, A1, A2, A3, code_valid, sw_stable
  );
endinterface

// File: rtl/nibble_input_latch_debounce_filter.sv
// debounce_filter: 2-flop synchroniser plus group debounce that accepts a value after DEBOUNCE_CYCLES stable cycles
module debounce_filter #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] s1_q, s2_q, cand_q, db_q;
  logic [CNT_W-1:0] cnt_q;
  // plain two-stage synchroniser, nothing between the stages
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  // restart the count on any change; accept the candidate once it has held long enough
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cand_q <= '0;
      cnt_q  <= '0;
      db_q   <= '0;
    end else if (s2_q != cand_q) begin
      cand_q <= s2_q;
      cnt_q  <= '0;
    end else if (cnt_q == LAST) begin
      db_q <= cand_q;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  assign q_o = db_q;
endmodule

// File: rtl/nibble_input_latch.sv
// nibble_input_latch: debounced switch code latched once per press; NIBBLE_AUTO_LOAD_EN adds load-on-switch-change
module nibble_input_latch
  import nibble_input_latch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_50MHZ,
  parameter int CNT_W           = 16
) (
  input logic                 clk,
  input logic                 rst,
  nibble_input_latch_if.slave bus
);
  logic [3:0] sw_db;
  logic       btn_db;
  logic       chg;
  logic       load;
  state_e     state_q, state_d;
  logic [3:0] code_q;
  logic       valid_q;
  debounce_filter #(.WIDTH(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_sw (
    .clk (clk),
    .rst (rst),
    .d_i (bus.sw_raw),
    .q_o (sw_db)
  );
  debounce_filter #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_btn (
    .clk (clk),
    .rst (rst),
    .d_i (bus.btn_load_raw),
    .q_o (btn_db)
  );
`ifdef NIBBLE_AUTO_LOAD_EN
  logic [3:0] sw_prev_q;
  // previous debounced switch value for change detection
  always_ff @(posedge clk or posedge rst)
    if (rst) sw_prev_q <= '0;
    else     sw_prev_q <= sw_db;
  assign chg = sw_db != sw_prev_q;
`else
  assign chg = 1'b0;
`endif
  // IDLE leaves on a press and WAIT_REL leaves on release, so the next state simply follows btn_db
  always_comb begin
    load    = state_q == ST_IDLE && (btn_db || chg);
    state_d = btn_db ? ST_WAIT_REL : ST_IDLE;
  end
  // one latch and one strobe per load; the latch takes the pre-edge debounced switches
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= load;
      code_q  <= load ? sw_db : code_q;
    end
  assign {bus.A3, bus.A2, bus.A1, bus.A0} = code_q;
  assign bus.code_valid = valid_q;
  assign bus.sw_stable  = sw_db;
endmodule
